// File: rtl/iob_intr_packetizer_pkg.sv
// iob_intr_packetizer_pkg: flit type and interrupt flit builders
`ifndef NOC_DATA_WIDTH
`include "iob_noc_define.sv"
`endif
package iob_intr_packetizer_pkg;
  localparam int FLIT_W = `NOC_DATA_WIDTH;
  typedef logic [FLIT_W-1:0] flit_t;
  function automatic flit_t mk_header(input logic [7:0] x, input logic [7:0] y);
    flit_t h;
    h = {14'b0, 5'b0, 3'b0, 8'b0, `NOC_FBITS_L1, 8'd1, `MSG_TYPE_INTERRUPT, 14'b0};
    h[`MSG_DST_X] = x;
    h[`MSG_DST_Y] = y;
    return h;
  endfunction
  function automatic flit_t mk_payload(input logic [63:0] d);
    return {d[63:16], 7'b0, d[8:0]};
  endfunction
endpackage

// File: rtl/iob_noc_define.sv
// iob_noc_define: shared NoC message field macros
`ifndef IOB_NOC_DEFINE_SV
`define IOB_NOC_DEFINE_SV
`define NOC_DATA_WIDTH 64
`define MSG_DST_X 49:42
`define MSG_DST_Y 41:34
`define NOC_FBITS_L1 4'b0000
`define MSG_TYPE_INTERRUPT 8'd32
`endif

// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter: round-robin grant starting at an internal pointer
module iob_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] ptr;
  // first asserted request at or after ptr; descending scan lets the nearest one win
  always_comb begin
    gnt_idx = ptr;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) gnt_idx = IW'((int'(ptr) + i) % N);
    gnt = |req ? N'(1) << gnt_idx : '0;
  end
  // pointer moves past the winner only when its transfer happens
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (advance) ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/iob_intr_packetizer.sv
// iob_intr_packetizer: arbitrate interrupt requests into 2-flit NoC packets through a bounded FIFO
`ifndef NOC_DATA_WIDTH
`include "iob_noc_define.sv"
`endif
module iob_intr_packetizer
  import iob_intr_packetizer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int TILES_X = 8,
  parameter int TILES_Y = 8,
  parameter int TILEID_W = 32,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_val,
  output logic [NUM_CH-1:0]          req_rdy,
  input  logic [NUM_CH*TILEID_W-1:0] req_tileid,
  input  logic [NUM_CH*64-1:0]       req_data,
  output logic                       noc_out_val,
  input  logic                       noc_out_rdy,
  output logic [`NOC_DATA_WIDTH-1:0] noc_out_data,
  output logic                       err_bad_tile,
  output logic [CW-1:0]              err_ch,
  output logic [15:0]                drop_cnt,
  output logic [LW-1:0]              fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [NUM_CH-1:0]   gnt;
  logic [CW-1:0]       gidx;
  logic                xfer, bad, wr, rd;
  logic [TILEID_W-1:0] tid;
  logic [63:0]         d;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  flit_t               mem [FIFO_DEPTH];
  iob_rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk(clk), .rst(rst), .req(req_val), .advance(xfer), .gnt(gnt), .gnt_idx(gidx)
  );
  // accept only with room for a whole packet, ignoring any same-cycle read
  always_comb begin
    req_rdy = (!rst && fifo_level <= LW'(FIFO_DEPTH - 2)) ? gnt : '0;
    xfer = |(req_val & req_rdy);
    tid = req_tileid[gidx*TILEID_W +: TILEID_W];
    d = req_data[gidx*64 +: 64];
    bad = tid >= TILEID_W'(TILES_X * TILES_Y);
    wr = xfer && !bad;
    noc_out_val = fifo_level != '0;
    rd = noc_out_val && noc_out_rdy;
    noc_out_data = noc_out_val ? mem[rd_ptr] : '0;
  end
  // header and payload land together so a packet is never split
  always_ff @(posedge clk)
    if (!rst && wr) begin
      mem[wr_ptr] <= mk_header(8'(tid % TILEID_W'(TILES_X)), 8'(tid / TILEID_W'(TILES_X)));
      mem[PW'(wr_ptr + 1'b1)] <= mk_payload(d);
    end
  // pointers, occupancy and drop reporting
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      err_bad_tile <= 1'b0;
      err_ch <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= wr ? PW'(wr_ptr + 2'd2) : wr_ptr;
      rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
      fifo_level <= fifo_level + (wr ? LW'(2) : LW'(0)) - LW'(rd);
      err_bad_tile <= xfer && bad;
      err_ch <= gidx;
      drop_cnt <= drop_cnt + 16'(xfer && bad && drop_cnt != 16'hFFFF);
    end
  a_level: assert property (@(posedge clk) disable iff (rst) fifo_level <= LW'(FIFO_DEPTH));
endmodule

// File: tb/tb_iob_intr_packetizer.sv
// tb_iob_intr_packetizer: random and directed checks against a flit-queue reference model
`ifndef NOC_DATA_WIDTH
`include "iob_noc_define.sv"
`endif
module tb_iob_intr_packetizer;
  localparam int N = 4, D = 16, TX = 8, TY = 8, TW = 32;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_val = '0, req_rdy;
  logic [N*TW-1:0] req_tileid = '0;
  logic [N*64-1:0] req_data = '0;
  logic noc_out_val, noc_out_rdy = 0;
  logic [`NOC_DATA_WIDTH-1:0] noc_out_data;
  logic err_bad_tile;
  logic [1:0] err_ch;
  logic [15:0] drop_cnt;
  logic [4:0] fifo_level;
  int n_chk = 0, n_err = 0;
  logic [63:0] q[$];
  int rr = 0, m_ch = 0, m_drop = 0;
  bit m_err = 0;
  iob_intr_packetizer dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_tileid(req_tileid),
    .req_data(req_data), .noc_out_val(noc_out_val), .noc_out_rdy(noc_out_rdy),
    .noc_out_data(noc_out_data), .err_bad_tile(err_bad_tile), .err_ch(err_ch),
    .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [63:0] hdr(input logic [31:0] t);
    return (64'(t % TX) << 42) | (64'(t / TX) << 34) | (64'(`NOC_FBITS_L1) << 30) |
           (64'd1 << 22) | (64'(`MSG_TYPE_INTERRUPT) << 14);
  endfunction
  task automatic put(input int ch, input logic [31:0] t, input logic [63:0] d);
    req_val[ch] = 1'b1;
    req_tileid[ch*TW +: TW] = t;
    req_data[ch*64 +: 64] = d;
  endtask
  task automatic step();
    int g;
    bit acc;
    logic [N-1:0] er;
    logic [31:0] t;
    logic [63:0] d;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && req_val[(rr + k) % N]) g = (rr + k) % N;
    acc = !rst && g >= 0 && q.size() <= D - 2;
    er = acc ? N'(1) << g : '0;
    check("req_rdy", req_rdy, er);
    check("noc_out_val", noc_out_val, q.size() != 0);
    check("noc_out_data", noc_out_data, q.size() != 0 ? q[0] : 64'd0);
    check("fifo_level", fifo_level, q.size());
    check("err_bad_tile", err_bad_tile, m_err);
    if (m_err) check("err_ch", err_ch, m_ch);
    check("drop_cnt", drop_cnt, m_drop);
    if (rst) begin
      q.delete();
      rr = 0;
      m_err = 0;
      m_drop = 0;
    end else begin
      if (q.size() != 0 && noc_out_rdy) void'(q.pop_front());
      m_err = 0;
      if (acc) begin
        t = req_tileid[g*TW +: TW];
        d = req_data[g*64 +: 64];
        if (t < TX * TY) begin
          q.push_back(hdr(t));
          q.push_back({d[63:16], 7'b0, d[8:0]});
        end else begin
          m_err = 1;
          m_ch = g;
          if (m_drop < 65535) m_drop++;
        end
        rr = (g + 1) % N;
      end
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    req_val = '0;
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    step();
    rst = 0;
    put(0, 9, 64'hDEAD_BEEF_0000_01FF);
    step();
    req_val = '0;
    check("t1_dst_x", noc_out_data[49:42], 1);
    check("t1_dst_y", noc_out_data[41:34], 1);
    noc_out_rdy = 1;
    step();
    check("t1_payload", noc_out_data, {48'hDEADBEEF0000, 7'b0, 9'h1FF});
    repeat (2) step();
    do_reset();
    for (int c = 0; c < N; c++) put(c, $urandom_range(0, TX*TY-1), {$urandom, $urandom});
    repeat (8) step();
    req_val = '0;
    repeat (10) step();
    do_reset();
    noc_out_rdy = 0;
    put(1, $urandom_range(0, TX*TY-1), {$urandom, $urandom});
    repeat (10) step();
    check("t3_full_level", fifo_level, 16);
    noc_out_rdy = 1;
    repeat (4) step();
    req_val = '0;
    repeat (20) step();
    put(2, 64, 64'h1234);
    step();
    req_val = '0;
    check("t4_err_pulse", err_bad_tile, 1);
    check("t4_err_ch", err_ch, 2);
    repeat (2) step();
    check("t4_drop_cnt", drop_cnt, 1);
    noc_out_rdy = 0;
    put(0, 5, 64'hCAFE);
    step();
    req_val = '0;
    noc_out_rdy = 1;
    step();
    noc_out_rdy = 0;
    rst = 1;
    step();
    rst = 0;
    noc_out_rdy = 1;
    check("t5_val_after_rst", noc_out_val, 0);
    repeat (3) step();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        req_val[c] = $urandom_range(0, 2) != 0;
        req_tileid[c*TW +: TW] = $urandom_range(0, 7) == 0 ? 32'(64 + $urandom_range(0, 999)) : 32'($urandom_range(0, 63));
        req_data[c*64 +: 64] = {$urandom, $urandom};
      end
      noc_out_rdy = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 299) == 0;
      step();
    end
    rst = 0;
    req_val = '0;
    noc_out_rdy = 1;
    repeat (20) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
